pxs_vga_timing_gen: RTL and testbench

Source end of the VGA pixel stream. Generates the 23-bit SCA stream (HSync, VSync, XCoord, YCoord, ActiveVideo) that every downstream Pxs stage consumes, such as colour adders and overlays. It contains the horizontal and vertical raster counters, derives sync and active-video from them, and registers the packed stream. It sits first in the pipeline, ahead of all pixel-colouring stages.

---
 rtl/pxs_pkg.sv | 38 +++
 rtl/pxs_vga_timing_gen_if.sv | 11 +
 rtl/pxs_wrap_counter.sv | 37 +++
 rtl/pxs_vga_timing_gen.sv | 101 ++++++++++
 tb/tb_pxs_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pxs_pkg.sv
// Shared definitions for the Pxs pixel-stream pipeline: SCA field layout,
// stream widths and the default 640x480@60 raster timing.
package pxs_pkg;

  localparam int ACTIVE      = 0;
  localparam int VSYNC       = 1;
  localparam int HSYNC       = 2;
  localparam int YCOORD_LSB  = 3;
  localparam int YCOORD_MSB  = 12;
  localparam int XCOORD_LSB  = 13;
  localparam int XCOORD_MSB  = 22;
  localparam int RGB_LSB     = 23;
  localparam int RGB_MSB     = 25;

  localparam int SCA_W       = 23;
  localparam int SCA_RGB_W   = 26;
  localparam int COORD_W     = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic logic [SCA_W-1:0] pack_sca(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic               hs,
    input logic               vs,
    input logic               av
  );
    return {x, y, hs, vs, av};
  endfunction

endpackage

// File: rtl/pxs_vga_timing_gen_if.sv
// Stream bundle leaving the timing generator: packed SCA word plus raster
// markers (line start, frame start, last pixel of frame).
interface pxs_vga_timing_gen_if;
  logic [pxs_pkg::SCA_W-1:0] sca;
  logic                      frame_start;
  logic                      line_start;
  logic                      frame_end;

  modport master (output sca, output frame_start, output line_start, output frame_end);
  modport slave  (input  sca, input  frame_start, input  line_start, input  frame_end);
endinterface

// File: rtl/pxs_wrap_counter.sv
// Enabled modulo-(MAX+1) counter; wrap_o is the carry out, high on an enabled
// cycle while the count sits at MAX.
module pxs_wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 799
) (
  input  logic             px_clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max;

  assign at_max = (count_q == WIDTH'(MAX));

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = en_i && at_max;

endmodule

// File: rtl/pxs_vga_timing_gen.sv
// Head of the Pxs pipeline: raster counters plus one register stage producing
// the SCA stream (coords, syncs, active video) and line/frame markers.
module pxs_vga_timing_gen
  import pxs_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                  px_clk,
  input  logic                  rst,
  input  logic                  px_ce,
  output logic [SCA_W-1:0]      VGA_SCA_Str_o,
  output logic                  frame_start_o,
  output logic                  line_start_o,
  pxs_vga_timing_gen_if.master  str_if
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
    $error("pxs_vga_timing_gen: H_TOT or V_TOT does not fit a 10-bit counter");
  end

  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] hc, vc;
  logic               h_wrap, v_wrap;

  pxs_wrap_counter #(.WIDTH(COORD_W), .MAX(H_TOT - 1)) u_hcnt (
    .px_clk  (px_clk),
    .rst     (rst),
    .en_i    (px_ce),
    .count_o (hc),
    .wrap_o  (h_wrap)
  );

  pxs_wrap_counter #(.WIDTH(COORD_W), .MAX(V_TOT - 1)) u_vcnt (
    .px_clk  (px_clk),
    .rst     (rst),
    .en_i    (px_ce && h_wrap),
    .count_o (vc),
    .wrap_o  (v_wrap)
  );

  logic             hsync, vsync, active;
  logic [SCA_W-1:0] sca_q, sca_d;
  logic             fs_q, fs_d, ls_q, ls_d, fe_q, fe_d;

  always_comb begin
    hsync  = (hc >= HS_START && hc < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync  = (vc >= VS_START && vc < VS_END) ? SYNC_POL : ~SYNC_POL;
    active = (hc < H_ACT) && (vc < V_ACT);
    sca_d  = sca_q;
    fs_d   = fs_q;
    ls_d   = ls_q;
    fe_d   = fe_q;
    if (px_ce) begin
      sca_d = pack_sca(hc, vc, hsync, vsync, active);
      fs_d  = (hc == '0) && (vc == '0);
      ls_d  = (hc == '0);
      fe_d  = v_wrap;
    end
  end

  // Output register stage: one enabled cycle behind the counters.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      sca_q <= pack_sca('0, '0, ~SYNC_POL, ~SYNC_POL, 1'b0);
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      sca_q <= sca_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
      fe_q  <= fe_d;
    end
  end

  assign VGA_SCA_Str_o      = sca_q;
  assign frame_start_o      = fs_q;
  assign line_start_o       = ls_q;
  assign str_if.sca         = sca_q;
  assign str_if.frame_start = fs_q;
  assign str_if.line_start  = ls_q;
  assign str_if.frame_end   = fe_q;

endmodule

// File: tb/tb_pxs_vga_timing_gen.sv
// Scoreboard bench: a 640x480 instance and a tiny-raster instance share
// clock/enable/reset; stimulus queues expected streams, a monitor compares.
module tb_pxs_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic px_ce = 1'b1;

  logic [22:0] sca_b, sca_s;
  logic        fs_b, ls_b, fs_s, ls_s;

  pxs_vga_timing_gen_if if_b ();
  pxs_vga_timing_gen_if if_s ();

  pxs_vga_timing_gen u_big (
    .px_clk        (clk),
    .rst           (rst),
    .px_ce         (px_ce),
    .VGA_SCA_Str_o (sca_b),
    .frame_start_o (fs_b),
    .line_start_o  (ls_b),
    .str_if        (if_b)
  );

  // 15 x 10 raster: hsync low for hc 10..12, vsync low for vc 7..8.
  pxs_vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .px_clk        (clk),
    .rst           (rst),
    .px_ce         (px_ce),
    .VGA_SCA_Str_o (sca_s),
    .frame_start_o (fs_s),
    .line_start_o  (ls_s),
    .str_if        (if_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          which;
    string       name;
    logic [22:0] sca;
    logic        fs;
    logic        ls;
    logic        fe;
    int          per;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  bit   which  = 1'b0;
  int   ht     = 800;
  int   nxt    = 0;
  int   cur_per = 0;

  task automatic push(input bit c, input string name, input logic [22:0] s,
                      input logic fs, input logic ls, input logic fe);
    exp_t e;
    e.chk = c; e.which = which; e.name = name; e.sca = s;
    e.fs = fs; e.ls = ls; e.fe = fe; e.per = cur_per;
    q.push_back(e);
  endtask

  task automatic tick(input bit ce, input bit r);
    @(negedge clk);
    px_ce = ce;
    rst   = r;
    push(1'b0, "", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
  endtask

  task automatic expect_px(input bit ce, input bit r, input string name,
                           input int x, input int y, input bit hs, input bit vs,
                           input bit av, input bit fs, input bit ls, input bit fe);
    @(negedge clk);
    px_ce = ce;
    rst   = r;
    push(1'b1, name, {10'(x), 10'(y), hs, vs, av}, fs, ls, fe);
    @(posedge clk);
    if (ce && !r) nxt++;
  endtask

  task automatic skip_to(input int x, input int y);
    while (nxt < y * ht + x) begin
      tick(1'b1, 1'b0);
      nxt++;
    end
  endtask

  // Monitor: compares queued expectations and measures small-raster frame period.
  int   cnt_s   = 0;
  bit   seen_s  = 1'b0;
  logic fsp_s   = 1'b0;

  initial begin
    exp_t        e;
    logic [22:0] a_sca, i_sca;
    logic        a_fs, a_ls, i_fe;
    int          per;
    forever begin
      @(posedge clk);
      #1;
      cnt_s++;
      per = 0;
      if (q.size() > 0) begin
        e   = q.pop_front();
        per = e.per;
        if (e.chk) begin
          a_sca = e.which ? sca_s : sca_b;
          a_fs  = e.which ? fs_s  : fs_b;
          a_ls  = e.which ? ls_s  : ls_b;
          i_sca = e.which ? if_s.sca : if_b.sca;
          i_fe  = e.which ? if_s.frame_end : if_b.frame_end;
          tests++;
          if (a_sca !== e.sca || a_fs !== e.fs || a_ls !== e.ls || i_fe !== e.fe) begin
            failed++;
            $display("FAIL %s: got X=%0d Y=%0d hs=%b vs=%b av=%b fs=%b ls=%b fe=%b, want X=%0d Y=%0d hs=%b vs=%b av=%b fs=%b ls=%b fe=%b",
                     e.name, a_sca[22:13], a_sca[12:3], a_sca[2], a_sca[1], a_sca[0], a_fs, a_ls, i_fe,
                     e.sca[22:13], e.sca[12:3], e.sca[2], e.sca[1], e.sca[0], e.fs, e.ls, e.fe);
          end
          tests++;
          if (i_sca !== e.sca) begin
            failed++;
            $display("FAIL %s_if: interface sca=%h, want %h", e.name, i_sca, e.sca);
          end
        end
      end
      if (fs_s && !fsp_s) begin
        if (seen_s && per != 0) begin
          tests++;
          if (cnt_s != per) begin
            failed++;
            $display("FAIL frame_period: got %0d clk cycles, want %0d", cnt_s, per);
          end
        end
        seen_s = 1'b1;
        cnt_s  = 0;
      end
      fsp_s = fs_s;
    end
  end

  initial begin
    // 640x480 instance
    which = 1'b0; ht = 800; cur_per = 0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    expect_px(1, 1, "reset",      0,   0, 1, 1, 0, 0, 0, 0);
    nxt = 0;
    expect_px(1, 0, "first_px",   0,   0, 1, 1, 1, 1, 1, 0);
    skip_to(639, 0);
    expect_px(1, 0, "x639",     639,   0, 1, 1, 1, 0, 0, 0);
    expect_px(1, 0, "x640",     640,   0, 1, 1, 0, 0, 0, 0);
    skip_to(655, 0);
    expect_px(1, 0, "x655",     655,   0, 1, 1, 0, 0, 0, 0);
    expect_px(1, 0, "x656",     656,   0, 0, 1, 0, 0, 0, 0);
    skip_to(751, 0);
    expect_px(1, 0, "x751",     751,   0, 0, 1, 0, 0, 0, 0);
    expect_px(1, 0, "x752",     752,   0, 1, 1, 0, 0, 0, 0);
    skip_to(799, 0);
    expect_px(1, 0, "x799",     799,   0, 1, 1, 0, 0, 0, 0);
    expect_px(1, 0, "line_wrap",  0,   1, 1, 1, 1, 0, 1, 0);
    skip_to(100, 1);
    expect_px(1, 0, "ce_x100",  100,   1, 1, 1, 1, 0, 0, 0);
    expect_px(0, 0, "ce_hold1", 100,   1, 1, 1, 1, 0, 0, 0);
    expect_px(0, 0, "ce_hold2", 100,   1, 1, 1, 1, 0, 0, 0);
    expect_px(1, 0, "ce_x101",  101,   1, 1, 1, 1, 0, 0, 0);
    skip_to(299, 1);
    expect_px(1, 0, "pre_rst",  299,   1, 1, 1, 1, 0, 0, 0);
    expect_px(1, 1, "mid_rst",    0,   0, 1, 1, 0, 0, 0, 0);
    nxt = 0;
    expect_px(1, 0, "post_rst",   0,   0, 1, 1, 1, 1, 1, 0);

    // 15x10 instance
    which = 1'b1; ht = 15; cur_per = 0;
    tick(1'b1, 1'b1);
    expect_px(1, 1, "s_reset",    0,   0, 1, 1, 0, 0, 0, 0);
    nxt = 0;
    expect_px(1, 0, "s_first",    0,   0, 1, 1, 1, 1, 1, 0);
    cur_per = 150;
    skip_to(14, 0);
    expect_px(1, 0, "s_x14",     14,   0, 1, 1, 0, 0, 0, 0);
    expect_px(1, 0, "s_line1",    0,   1, 1, 1, 1, 0, 1, 0);
    skip_to(3, 6);
    expect_px(1, 0, "s_vblank",   3,   6, 1, 1, 0, 0, 0, 0);
    skip_to(14, 6);
    expect_px(1, 0, "s_pre_vs",  14,   6, 1, 1, 0, 0, 0, 0);
    expect_px(1, 0, "s_vs_on",    0,   7, 1, 0, 0, 0, 1, 0);
    skip_to(11, 7);
    expect_px(1, 0, "s_hs_vs",   11,   7, 0, 0, 0, 0, 0, 0);
    skip_to(14, 8);
    expect_px(1, 0, "s_vs_last", 14,   8, 1, 0, 0, 0, 0, 0);
    expect_px(1, 0, "s_vs_off",   0,   9, 1, 1, 0, 0, 1, 0);
    skip_to(14, 9);
    expect_px(1, 0, "s_last",    14,   9, 1, 1, 0, 0, 0, 1);
    expect_px(1, 0, "s_fwrap",    0,   0, 1, 1, 1, 1, 1, 0);
    cur_per = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end
    cur_per = 300;
    for (int i = 0; i < 150; i++) begin
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end
    cur_per = 0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
